memory_access: RTL and testbench

RV32I memory-access stage. It sits directly downstream of the execute stage and consumes `EX_MEM_ALU_OUT`, `EX_MEM_IR`, `EX_MEM_PC` and the store operand. It performs byte, halfword and word loads and stores over a req/ack data-memory bus, then registers the `MEM_WB_*` bundle for write-back. It raises `STALL` while a memory transaction is outstanding, so upstream holds its registers.

---
 rtl/rv32i_pkg.sv | 72 +++++++
 rtl/load_align.sv | 36 +++
 rtl/memory_access.sv | 145 ++++++++++++++
 tb/tb_memory_access.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, memory-stage FSM states.
// Latency: n/a (constants and pure combinational helper functions).
// Backpressure: n/a.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MA_IDLE = 2'b00,
    MA_BUSY = 2'b01,
    MA_RESP = 2'b10
  } ma_state_t;

  // Decode of the EX bundle as seen by the memory stage.
  typedef struct packed {
    logic       is_mem;    // load or store opcode
    logic       is_store;
    logic       f3_ok;     // memory opcode with a legal funct3
    logic       misalign;  // only ever set when misalignment traps
    logic [1:0] lane;      // low address bits after forced alignment
  } mem_dec_t;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3[1:0] encodes the access size for every legal load/store.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return |a;
      default: return 1'b0;
    endcase
  endfunction

  // Clears the low address bits that the access size cannot use.
  function automatic logic [1:0] align_lane(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return {a[1], 1'b0};
      2'b10:   return 2'b00;
      default: return a;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across all lanes; BE picks the live ones.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] b);
    case (f3[1:0])
      2'b00:   return {4{b[7:0]}};
      2'b01:   return {2{b[15:0]}};
      default: return b;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the byte/half lane of a read word and sign- or zero-extends it.
// Latency: combinational. Backpressure: none.
// Ports: rdata (read word), addr (low address bits), funct3 (load type), lmd (result).
module load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] lmd
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    lmd = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   lmd = {24'h0, byte_sel};
      F3_H:    lmd = {{16{half_sel[15]}}, half_sel};
      F3_HU:   lmd = {16'h0, half_sel};
      default: lmd = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// RV32I memory-access stage: byte/half/word loads and stores over a req/ack bus,
// registers the MEM_WB bundle. Latency: pass-through 1 cycle, memory op ack-cycle+1.
// Backpressure: STALL is high whenever the FSM is not IDLE; the EX bundle is taken in IDLE only.
// Ports: clk/rst; EX_MEM_* bundle in; STALL out; DMEM_* req/ack data-memory bus;
//        MEM_WB_* registered bundle out with a one-cycle MEM_WB_VALID pulse.
// Build option: define MEM_MISALIGN_TRAP_EN to turn misaligned half/word accesses
// into exceptions instead of silently aligning them.
module memory_access
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_MEM_VALID,
  input  logic [31:0]       EX_MEM_ALU_OUT,
  input  logic [31:0]       EX_MEM_IR,
  input  logic [31:0]       EX_MEM_PC,
  input  logic [31:0]       EX_MEM_B,
  output logic              STALL,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [ADDR_W-1:0] DMEM_ADDR,
  output logic [31:0]       DMEM_WDATA,
  output logic [3:0]        DMEM_BE,
  input  logic [31:0]       DMEM_RDATA,
  input  logic              DMEM_ACK,
  output logic              MEM_WB_VALID,
  output logic [31:0]       MEM_WB_IR,
  output logic [31:0]       MEM_WB_PC,
  output logic [31:0]       MEM_WB_ALU_OUT,
  output logic [31:0]       MEM_WB_LMD,
  output logic              MEM_WB_EXC
);

  ma_state_t state;

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [ADDR_W-1:0] ea;
  mem_dec_t          dec;
  logic              issue;
  logic              exc;

  // Bundle of the outstanding memory op; MEM_WB_* must not change until its ack.
  logic [31:0] pend_ir;
  logic [31:0] pend_pc;
  logic [31:0] pend_alu;
  logic [1:0]  pend_lane;
  logic [31:0] ld_lmd;

  assign opcode = EX_MEM_IR[6:0];
  assign f3     = EX_MEM_IR[14:12];
  assign ea     = EX_MEM_ALU_OUT[ADDR_W-1:0];

  always_comb begin
    dec          = '0;
    dec.is_store = (opcode == OP_STORE);
    dec.is_mem   = (opcode == OP_LOAD) || dec.is_store;
    dec.f3_ok    = dec.is_mem && f3_legal(dec.is_store, f3);
`ifdef MEM_MISALIGN_TRAP_EN
    dec.misalign = misaligned(f3, ea[1:0]);
`else
    dec.misalign = 1'b0;
`endif
    dec.lane     = align_lane(f3, ea[1:0]);
  end

  // Illegal funct3 and (when trapping) misaligned accesses fall back to pass-through.
  assign issue = dec.f3_ok & ~dec.misalign;
  assign exc   = dec.is_mem & ~issue;

  assign STALL = (state != MA_IDLE);

  load_align u_load_align (
    .rdata  (DMEM_RDATA),
    .addr   (pend_lane),
    .funct3 (pend_ir[14:12]),
    .lmd    (ld_lmd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= MA_IDLE;
      DMEM_REQ       <= 1'b0;
      DMEM_WE        <= 1'b0;
      DMEM_ADDR      <= '0;
      DMEM_WDATA     <= '0;
      DMEM_BE        <= '0;
      MEM_WB_VALID   <= 1'b0;
      MEM_WB_IR      <= '0;
      MEM_WB_PC      <= '0;
      MEM_WB_ALU_OUT <= '0;
      MEM_WB_LMD     <= '0;
      MEM_WB_EXC     <= 1'b0;
      pend_ir        <= '0;
      pend_pc        <= '0;
      pend_alu       <= '0;
      pend_lane      <= '0;
    end else begin
      MEM_WB_VALID <= 1'b0;
      case (state)
        MA_IDLE: begin
          if (EX_MEM_VALID) begin
            if (issue) begin
              pend_ir    <= EX_MEM_IR;
              pend_pc    <= EX_MEM_PC;
              pend_alu   <= EX_MEM_ALU_OUT;
              pend_lane  <= dec.lane;
              DMEM_REQ   <= 1'b1;
              DMEM_WE    <= dec.is_store;
              DMEM_ADDR  <= {ea[ADDR_W-1:2], 2'b00};
              DMEM_BE    <= lane_be(f3, dec.lane);
              DMEM_WDATA <= dec.is_store ? store_data(f3, EX_MEM_B) : 32'h0;
              state      <= MA_BUSY;
            end else begin
              MEM_WB_VALID   <= 1'b1;
              MEM_WB_IR      <= EX_MEM_IR;
              MEM_WB_PC      <= EX_MEM_PC;
              MEM_WB_ALU_OUT <= EX_MEM_ALU_OUT;
              MEM_WB_LMD     <= 32'h0;
              MEM_WB_EXC     <= exc;
            end
          end
        end
        MA_BUSY: begin
          // Request and all DMEM_* fields stay frozen until the ack.
          if (DMEM_ACK) begin
            DMEM_REQ       <= 1'b0;
            MEM_WB_VALID   <= 1'b1;
            MEM_WB_IR      <= pend_ir;
            MEM_WB_PC      <= pend_pc;
            MEM_WB_ALU_OUT <= pend_alu;
            MEM_WB_LMD     <= DMEM_WE ? 32'h0 : ld_lmd;
            MEM_WB_EXC     <= 1'b0;
            state          <= MA_RESP;
          end
        end
        MA_RESP: state <= MA_IDLE;
        default: state <= MA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus randomized
// loads/stores compared against an arithmetic reference model.
// Works with or without MEM_MISALIGN_TRAP_EN defined.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        EX_MEM_VALID = 1'b0;
  logic [31:0] EX_MEM_ALU_OUT = '0;
  logic [31:0] EX_MEM_IR = '0;
  logic [31:0] EX_MEM_PC = '0;
  logic [31:0] EX_MEM_B = '0;
  logic        STALL;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_RDATA = '0;
  logic        DMEM_ACK = 1'b0;
  logic        MEM_WB_VALID;
  logic [31:0] MEM_WB_IR;
  logic [31:0] MEM_WB_PC;
  logic [31:0] MEM_WB_ALU_OUT;
  logic [31:0] MEM_WB_LMD;
  logic        MEM_WB_EXC;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  memory_access #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .EX_MEM_VALID   (EX_MEM_VALID),
    .EX_MEM_ALU_OUT (EX_MEM_ALU_OUT),
    .EX_MEM_IR      (EX_MEM_IR),
    .EX_MEM_PC      (EX_MEM_PC),
    .EX_MEM_B       (EX_MEM_B),
    .STALL          (STALL),
    .DMEM_REQ       (DMEM_REQ),
    .DMEM_WE        (DMEM_WE),
    .DMEM_ADDR      (DMEM_ADDR),
    .DMEM_WDATA     (DMEM_WDATA),
    .DMEM_BE        (DMEM_BE),
    .DMEM_RDATA     (DMEM_RDATA),
    .DMEM_ACK       (DMEM_ACK),
    .MEM_WB_VALID   (MEM_WB_VALID),
    .MEM_WB_IR      (MEM_WB_IR),
    .MEM_WB_PC      (MEM_WB_PC),
    .MEM_WB_ALU_OUT (MEM_WB_ALU_OUT),
    .MEM_WB_LMD     (MEM_WB_LMD),
    .MEM_WB_EXC     (MEM_WB_EXC)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          issue;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] lmd;
    logic        exc;
  } exp_t;

  typedef struct {
    logic        stall_at_accept;
    int          accept_at;
    int          valid_at;
    int          lat;
    int          stall_cyc;
    int          req_cnt;
    bit          req_seen;
    bit          stable;
    bit          hold_ok;
    bit          extra_pulse;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] lmd;
    logic        exc;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] ir;
    ir = $urandom;
    ir[6:0] = op;
    ir[14:12] = f3;
    return ir;
  endfunction

  // Reference: access size from funct3, alignment by modulo, lanes by shifting.
  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] alu,
                                 input logic [31:0] b, input logic [31:0] rdata);
    exp_t e;
    int unsigned size;
    int unsigned lane;
    logic [31:0] eff;
    logic [31:0] mask;
    logic [31:0] val;
    logic [2:0] f3;
    bit ld, st, legal, mis;
    e = '{default: 0};
    f3 = ir[14:12];
    ld = (ir[6:0] == 7'h03);
    st = (ir[6:0] == 7'h23);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : st ? (f3 <= 3'd2) : 1'b0;
    mis = (alu % size) != 0;
`ifdef MEM_MISALIGN_TRAP_EN
    e.issue = legal && !mis;
`else
    e.issue = legal;
`endif
    e.exc = (ld || st) && !e.issue;
    eff = alu - (alu % size);
    e.addr = eff & 32'hFFFF_FFFC;
    lane = eff % 4;
    e.we = st;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
    e.be = 4'(((1 << size) - 1) << lane);
    e.wdata = (size == 1) ? {24'h0, b[7:0]} * 32'h0101_0101 :
              (size == 2) ? {16'h0, b[15:0]} * 32'h0001_0001 : b;
    val = (rdata >> (8 * lane)) & mask;
    if (size < 4 && !f3[2] && val[8 * size - 1]) val = val | ~mask;
    e.lmd = (ld && e.issue) ? val : 32'h0;
    return e;
  endfunction

  // Presents one bundle, plays a memory that acks on the delay-th request cycle,
  // and records what the DUT did until the cycle after MEM_WB_VALID.
  task automatic do_txn(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] b, input logic [31:0] rdata, input int delay,
                        output obs_t o);
    o = '{default: 0};
    o.stable = 1;
    o.hold_ok = 1;
    o.stall_at_accept = STALL;
    o.accept_at = cyc;
    EX_MEM_VALID = 1'b1;
    EX_MEM_IR = ir;
    EX_MEM_PC = pc;
    EX_MEM_ALU_OUT = alu;
    EX_MEM_B = b;
    tick();
    EX_MEM_VALID = 1'b0;
    EX_MEM_IR = $urandom;
    EX_MEM_PC = $urandom;
    EX_MEM_ALU_OUT = $urandom;
    EX_MEM_B = $urandom;
    for (int c = 1; c <= 64; c++) begin
      if (o.lat != 0) begin
        o.hold_ok = (MEM_WB_IR === o.ir) && (MEM_WB_PC === o.pc) &&
                    (MEM_WB_ALU_OUT === o.alu) && (MEM_WB_LMD === o.lmd) &&
                    (MEM_WB_EXC === o.exc);
        o.extra_pulse = (MEM_WB_VALID !== 1'b0);
        break;
      end
      if (STALL === 1'b1) o.stall_cyc++;
      if (DMEM_REQ === 1'b1) begin
        if (!o.req_seen) begin
          o.req_seen = 1;
          o.we = DMEM_WE;
          o.addr = DMEM_ADDR;
          o.wdata = DMEM_WDATA;
          o.be = DMEM_BE;
        end else if ({DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BE} !== {o.we, o.addr, o.wdata, o.be}) begin
          o.stable = 0;
        end
        o.req_cnt++;
      end
      DMEM_ACK = (DMEM_REQ === 1'b1) && (o.req_cnt == delay);
      DMEM_RDATA = DMEM_ACK ? rdata : $urandom;
      if (MEM_WB_VALID === 1'b1) begin
        o.lat = c;
        o.valid_at = cyc;
        o.ir = MEM_WB_IR;
        o.pc = MEM_WB_PC;
        o.alu = MEM_WB_ALU_OUT;
        o.lmd = MEM_WB_LMD;
        o.exc = MEM_WB_EXC;
      end
      tick();
    end
    DMEM_ACK = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({DMEM_REQ, DMEM_WE, DMEM_BE, DMEM_ADDR, DMEM_WDATA, STALL} !== '0) begin
      errors++;
      $display("FAIL reset_dmem got req=%b we=%b be=%b addr=%h wdata=%h stall=%b exp all 0",
               DMEM_REQ, DMEM_WE, DMEM_BE, DMEM_ADDR, DMEM_WDATA, STALL);
    end
    checks++;
    if ({MEM_WB_VALID, MEM_WB_IR, MEM_WB_PC, MEM_WB_ALU_OUT, MEM_WB_LMD, MEM_WB_EXC} !== '0) begin
      errors++;
      $display("FAIL reset_memwb got v=%b ir=%h pc=%h alu=%h lmd=%h exc=%b exp all 0",
               MEM_WB_VALID, MEM_WB_IR, MEM_WB_PC, MEM_WB_ALU_OUT, MEM_WB_LMD, MEM_WB_EXC);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    obs_t o;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] alu;
    do_txn(32'h00B5_0533, 32'h0000_0040, 32'h0000_1234, 32'h5555_AAAA, 32'h0, 1, o);
    checks++;
    if (o.lat != 1 || o.stall_cyc != 0 || o.stall_at_accept !== 1'b0 || o.req_seen) begin
      errors++;
      $display("FAIL add_timing got lat=%0d stall=%0d req=%0d exp lat=1 stall=0 req=0",
               o.lat, o.stall_cyc, o.req_seen);
    end
    checks++;
    if ({o.alu, o.lmd, o.exc, o.pc} !== {32'h1234, 32'h0, 1'b0, 32'h40}) begin
      errors++;
      $display("FAIL add_data got alu=%h lmd=%h exc=%b pc=%h exp 1234 0 0 40", o.alu, o.lmd, o.exc, o.pc);
    end
    for (int i = 0; i < 16; i++) begin
      ir = $urandom;
      if (ir[6:0] == 7'h03 || ir[6:0] == 7'h23) ir[4] = ~ir[4];
      pc = $urandom;
      alu = $urandom;
      do_txn(ir, pc, alu, $urandom, $urandom, 1, o);
      checks++;
      if (o.lat != 1 || o.req_seen || o.stall_cyc != 0 ||
          {o.ir, o.pc, o.alu, o.lmd, o.exc} !== {ir, pc, alu, 32'h0, 1'b0} ||
          !o.hold_ok || o.extra_pulse) begin
        errors++;
        $display("FAIL pass_rnd it=%0d got lat=%0d ir=%h alu=%h lmd=%h exc=%b exp lat=1 ir=%h alu=%h lmd=0 exc=0",
                 i, o.lat, o.ir, o.alu, o.lmd, o.exc, ir, alu);
      end
    end
  endtask

  task automatic test_store_byte();
    obs_t o;
    do_txn(mk_ir(7'h23, 3'b000), 32'h80, 32'h0000_0103, 32'hAABB_CCDD, 32'h0, 1, o);
    checks++;
    if ({o.be, o.wdata, o.addr, o.we} !== {4'b1000, 32'hDDDD_DDDD, 32'h0000_0100, 1'b1}) begin
      errors++;
      $display("FAIL sb_bus got be=%b wdata=%h addr=%h we=%b exp 1000 dddddddd 00000100 1",
               o.be, o.wdata, o.addr, o.we);
    end
    checks++;
    if (o.lat != 2 || o.stall_cyc != 2 || o.lmd !== 32'h0 || o.exc !== 1'b0) begin
      errors++;
      $display("FAIL sb_done got lat=%0d stall=%0d lmd=%h exc=%b exp 2 2 0 0", o.lat, o.stall_cyc, o.lmd, o.exc);
    end
  endtask

  task automatic test_load_byte();
    obs_t o;
    do_txn(mk_ir(7'h03, 3'b000), 32'h84, 32'h0000_0102, 32'h0, 32'h0080_FF00, 3, o);
    checks++;
    if (o.lmd !== 32'hFFFF_FF80 || o.addr !== 32'h100 || o.we !== 1'b0) begin
      errors++;
      $display("FAIL lb_data got lmd=%h addr=%h we=%b exp ffffff80 100 0", o.lmd, o.addr, o.we);
    end
    checks++;
    if (o.stall_cyc != 4 || o.lat != 4 || o.req_cnt != 3 || !o.stable) begin
      errors++;
      $display("FAIL lb_timing got stall=%0d lat=%0d req=%0d stable=%0d exp 4 4 3 1",
               o.stall_cyc, o.lat, o.req_cnt, o.stable);
    end
    do_txn(mk_ir(7'h03, 3'b100), 32'h88, 32'h0000_0102, 32'h0, 32'h0080_FF00, 2, o);
    checks++;
    if (o.lmd !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_data got lmd=%h exp 00000080", o.lmd);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    do_txn(mk_ir(7'h03, 3'b001), 32'h8C, 32'h0000_0101, 32'h0, 32'h1234_8765, 1, o);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++;
    if (o.req_seen || o.exc !== 1'b1 || o.lmd !== 32'h0 || o.lat != 1) begin
      errors++;
      $display("FAIL lh_mis got req=%0d exc=%b lmd=%h lat=%0d exp 0 1 0 1", o.req_seen, o.exc, o.lmd, o.lat);
    end
`else
    checks++;
    if (!o.req_seen || o.addr !== 32'h100 || o.lmd !== 32'hFFFF_8765 || o.exc !== 1'b0) begin
      errors++;
      $display("FAIL lh_mis got req=%0d addr=%h lmd=%h exc=%b exp 1 100 ffff8765 0",
               o.req_seen, o.addr, o.lmd, o.exc);
    end
`endif
  endtask

  task automatic test_illegal_f3();
    obs_t o;
    do_txn(mk_ir(7'h03, 3'b011), 32'h90, 32'h200, 32'h0, 32'h0, 1, o);
    checks++;
    if (o.req_seen || o.exc !== 1'b1 || o.lmd !== 32'h0 || o.lat != 1) begin
      errors++;
      $display("FAIL ld_f3 got req=%0d exc=%b lmd=%h lat=%0d exp 0 1 0 1", o.req_seen, o.exc, o.lmd, o.lat);
    end
    do_txn(mk_ir(7'h23, 3'b100), 32'h94, 32'h200, 32'h0, 32'h0, 1, o);
    checks++;
    if (o.req_seen || o.exc !== 1'b1 || o.lat != 1) begin
      errors++;
      $display("FAIL st_f3 got req=%0d exc=%b lat=%0d exp 0 1 1", o.req_seen, o.exc, o.lat);
    end
  endtask

  task automatic test_spurious_ack();
    obs_t o;
    DMEM_ACK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({STALL, MEM_WB_VALID, DMEM_REQ} !== 3'b000) begin
        errors++;
        $display("FAIL spur_ack it=%0d got stall=%b v=%b req=%b exp 000", i, STALL, MEM_WB_VALID, DMEM_REQ);
      end
    end
    DMEM_ACK = 1'b0;
    do_txn(mk_ir(7'h03, 3'b010), 32'h98, 32'h300, 32'h0, 32'hCAFE_F00D, 2, o);
    checks++;
    if (o.lmd !== 32'hCAFE_F00D || o.lat != 3) begin
      errors++;
      $display("FAIL spur_lw got lmd=%h lat=%0d exp cafef00d 3", o.lmd, o.lat);
    end
  endtask

  task automatic test_reset_busy();
    obs_t o;
    int bad;
    EX_MEM_VALID = 1'b1;
    EX_MEM_IR = mk_ir(7'h03, 3'b010);
    EX_MEM_ALU_OUT = 32'h400;
    EX_MEM_PC = 32'hA0;
    tick();
    EX_MEM_VALID = 1'b0;
    checks++;
    if (DMEM_REQ !== 1'b1 || STALL !== 1'b1) begin
      errors++;
      $display("FAIL rstb_req got req=%b stall=%b exp 1 1", DMEM_REQ, STALL);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({DMEM_REQ, DMEM_WE, DMEM_BE, DMEM_ADDR, DMEM_WDATA, STALL, MEM_WB_VALID,
         MEM_WB_IR, MEM_WB_PC, MEM_WB_ALU_OUT, MEM_WB_LMD, MEM_WB_EXC} !== '0) begin
      errors++;
      $display("FAIL rstb_zero got req=%b be=%b addr=%h stall=%b v=%b ir=%h exp all 0",
               DMEM_REQ, DMEM_BE, DMEM_ADDR, STALL, MEM_WB_VALID, MEM_WB_IR);
    end
    tick();
    rst = 1'b0;
    tick();
    DMEM_ACK = 1'b1;
    DMEM_RDATA = 32'h1111_2222;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      DMEM_ACK = 1'b0;
      if ({MEM_WB_VALID, STALL, DMEM_REQ} !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstb_late_ack got %0d active cycles exp 0", bad);
    end
    do_txn(mk_ir(7'h03, 3'b010), 32'hA4, 32'h404, 32'h0, 32'h3333_4444, 1, o);
    checks++;
    if (o.lmd !== 32'h3333_4444 || o.lat != 2 || o.addr !== 32'h404) begin
      errors++;
      $display("FAIL rstb_lw got lmd=%h lat=%0d addr=%h exp 33334444 2 404", o.lmd, o.lat, o.addr);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1;
    obs_t o2;
    do_txn(mk_ir(7'h23, 3'b010), 32'hB0, 32'h500, 32'h0BAD_BEEF, 32'h0, 1, o1);
    do_txn(mk_ir(7'h03, 3'b010), 32'hB4, 32'h500, 32'h0, 32'h0BAD_BEEF, 1, o2);
    checks++;
    if (o2.accept_at != o1.valid_at + 1 || o2.stall_at_accept !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got accept=%0d stall=%b exp accept=%0d stall=0",
               o2.accept_at, o2.stall_at_accept, o1.valid_at + 1);
    end
    checks++;
    if (o2.valid_at - o1.valid_at != 3) begin
      errors++;
      $display("FAIL b2b_gap got %0d exp 3", o2.valid_at - o1.valid_at);
    end
    checks++;
    if (o1.be !== 4'b1111 || o1.wdata !== 32'h0BAD_BEEF || o2.lmd !== 32'h0BAD_BEEF) begin
      errors++;
      $display("FAIL b2b_data got be=%b wdata=%h lmd=%h exp 1111 0badbeef 0badbeef", o1.be, o1.wdata, o2.lmd);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] b;
    logic [31:0] rd;
    logic [2:0] f3;
    int d;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom);
      ir = mk_ir(($urandom_range(0, 1) == 0) ? 7'h03 : 7'h23, f3);
      pc = $urandom;
      alu = $urandom;
      b = $urandom;
      rd = $urandom;
      d = $urandom_range(1, 4);
      e = model(ir, alu, b, rd);
      do_txn(ir, pc, alu, b, rd, d, o);
      checks++;
      if (o.lat != (e.issue ? d + 1 : 1) || o.req_seen != e.issue) begin
        errors++;
        $display("FAIL rnd_timing it=%0d got lat=%0d req=%0d exp lat=%0d req=%0d",
                 i, o.lat, o.req_seen, e.issue ? d + 1 : 1, e.issue);
      end
      checks++;
      if (e.issue && ({o.we, o.addr} !== {e.we, e.addr} || !o.stable)) begin
        errors++;
        $display("FAIL rnd_addr it=%0d got we=%b addr=%h stable=%0d exp we=%b addr=%h",
                 i, o.we, o.addr, o.stable, e.we, e.addr);
      end
      checks++;
      if (e.issue && e.we && {o.be, o.wdata} !== {e.be, e.wdata}) begin
        errors++;
        $display("FAIL rnd_store it=%0d got be=%b wdata=%h exp be=%b wdata=%h", i, o.be, o.wdata, e.be, e.wdata);
      end
      checks++;
      if ({o.lmd, o.exc} !== {e.lmd, e.exc}) begin
        errors++;
        $display("FAIL rnd_result it=%0d ir=%h alu=%h got lmd=%h exc=%b exp lmd=%h exc=%b",
                 i, ir, alu, o.lmd, o.exc, e.lmd, e.exc);
      end
      checks++;
      if ({o.ir, o.pc, o.alu} !== {ir, pc, alu} || !o.hold_ok || o.extra_pulse) begin
        errors++;
        $display("FAIL rnd_bundle it=%0d got ir=%h pc=%h alu=%h hold=%0d extra=%0d exp ir=%h pc=%h alu=%h",
                 i, o.ir, o.pc, o.alu, o.hold_ok, o.extra_pulse, ir, pc, alu);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_passthrough();
    test_store_byte();
    test_load_byte();
    test_misalign();
    test_illegal_f3();
    test_spurious_ack();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
